lvds_frame_sched: RTL and testbench

LVDS_FRAME_SCHED -- requirements
Module: lvds_frame_sched

---
 rtl/lvds_frame_sched.sv | 139 +++++++++++++
 tb/tb_lvds_frame_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_frame_sched.sv
// Burst scheduler for a 2-lane LVDS link: each frame sends a 2-byte sync header, then
// FRAME_BYTES payload bytes. Bytes go out as 4 nibble phases; a gap separates frames.
module lvds_frame_sched #(
  parameter int unsigned FRAME_BYTES = 896,
  parameter int unsigned FRAME_NUM   = 10,
  parameter int unsigned GAP_CYC     = 16,
  parameter logic [15:0] SYNC_WORD   = 16'hEB90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        data0,
  output logic        data1,
  output logic        flag,
  output logic        busy,
  output logic        frame_start,
  output logic        done,
  output logic [15:0] frame_idx
);

  typedef enum logic [2:0] {IDLE, HEAD, PAYLOAD, GAP, DONE} state_t;

  localparam logic [15:0] LAST_BYTE  = 16'(FRAME_BYTES - 1);
  localparam logic [15:0] LAST_FRAME = 16'(FRAME_NUM - 1);
  localparam logic [7:0]  LAST_GAP   = 8'(GAP_CYC - 1);

  state_t      state;
  logic [15:0] pay_cnt;
  logic        pay_last;
  logic        hdr_sel;
  logic [7:0]  gap_cnt;
  logic [7:0]  sh;
  logic [1:0]  ph;
  logic        full;
  logic        load_pt;
  logic        xfer;

  // A new byte can enter when the serializer is empty or shifting out its last phase.
  assign load_pt    = !full || (ph == 2'd3);
  assign byte_ready = (state == PAYLOAD) && !pay_last && load_pt;
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= IDLE;
      pay_cnt     <= '0;
      pay_last    <= 1'b0;
      hdr_sel     <= 1'b0;
      gap_cnt     <= '0;
      sh          <= '0;
      ph          <= '0;
      full        <= 1'b0;
      data0       <= 1'b0;
      data1       <= 1'b0;
      flag        <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      frame_idx   <= '0;
    end else begin
      frame_start <= 1'b0;
      done        <= 1'b0;
      // Lanes show the serializer contents one cycle after they are loaded.
      data0 <= full & sh[ph];
      data1 <= full & sh[{1'b1, ph}];
      flag  <= full;
      if (full && ph != 2'd3) ph <= ph + 2'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= HEAD;
            busy        <= 1'b1;
            frame_start <= 1'b1;
            frame_idx   <= '0;
            hdr_sel     <= 1'b0;
          end
        end
        HEAD: begin
          if (load_pt) begin
            full    <= 1'b1;
            ph      <= 2'd0;
            sh      <= hdr_sel ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
            hdr_sel <= 1'b1;
            if (hdr_sel) begin
              state    <= PAYLOAD;
              pay_cnt  <= '0;
              pay_last <= 1'b0;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            sh   <= byte_data;
            full <= 1'b1;
            ph   <= 2'd0;
            if (pay_cnt == LAST_BYTE) pay_last <= 1'b1;
            else                      pay_cnt  <= pay_cnt + 16'd1;
          end else if (full && ph == 2'd3) begin
            full <= 1'b0;
          end
          // Intermediate frames hand over to the gap as the last phase leaves;
          // the final frame waits until the lanes are quiet before signalling done.
          if (pay_last && frame_idx != LAST_FRAME && full && ph == 2'd3) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
          if (pay_last && frame_idx == LAST_FRAME && !full) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == LAST_GAP) begin
            // First header byte loads on entry so the gap stays exactly GAP_CYC lane cycles.
            state       <= HEAD;
            frame_start <= 1'b1;
            frame_idx   <= frame_idx + 16'd1;
            full        <= 1'b1;
            ph          <= 2'd0;
            sh          <= SYNC_WORD[15:8];
            hdr_sel     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_frame_sched.sv
// Directed bench for lvds_frame_sched: a byte scoreboard checks every lane phase, and
// per-burst timing statistics are checked against hand-derived cycle numbers.
module tb_lvds_frame_sched;
  localparam int FB = 4;
  localparam int FN = 2;
  localparam int GC = 3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_valid = 1'b0;
  logic byte_ready, data0, data1, flag, busy, frame_start, done;
  logic [15:0] frame_idx;

  int checks = 0, errors = 0;

  lvds_frame_sched #(.FRAME_BYTES(FB), .FRAME_NUM(FN), .GAP_CYC(GC), .SYNC_WORD(16'hEB90)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .data0(data0), .data1(data1), .flag(flag), .busy(busy),
    .frame_start(frame_start), .done(done), .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected bytes in lane order; header pushed at frame_start, payload at transfer.
  logic [7:0] exp_q[$];
  int  mph = 0;
  bit  sb_en = 1'b0;
  always @(negedge clk) begin
    logic [1:0] o, e;
    if (sb_en && frame_start) begin
      exp_q.push_back(8'hEB);
      exp_q.push_back(8'h90);
    end
    if (sb_en && flag) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        o = {data1, data0};
        e = {exp_q[0][mph + 4], exp_q[0][mph]};
        chk("lane_bits", 32'(o), 32'(e));
        mph++;
        if (mph == 4) begin
          mph = 0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Byte source: always valid except an optional 5-cycle underflow before byte 2.
  bit src_en = 1'b0, take = 1'b0, hold_arm = 1'b0;
  int src_idx = 0, hold_cnt = 0;
  logic [7:0] src_base = '0;
  always @(negedge clk) begin
    if (take) src_idx++;
    if (hold_arm && byte_ready && src_idx == 2) begin
      hold_arm = 1'b0;
      hold_cnt = 5;
    end
    if (hold_cnt > 0) begin
      byte_valid = 1'b0;
      hold_cnt--;
    end else begin
      byte_valid = src_en;
    end
    byte_data = src_base + 8'(src_idx);
    take = byte_valid && byte_ready;
    if (take && sb_en) exp_q.push_back(byte_data);
  end

  // Per-burst statistics; t=0 is the first cycle after the edge that samples start.
  int t, nflag, first_flag, lowrun, ndone, done_t, busy_drop, nfs;
  int runs[$];
  int fs_t[$];
  logic [15:0] fs_idx[$];
  logic [3:0] a5_d0, a5_d1;

  task automatic clear_stats();
    t = -1; nflag = 0; first_flag = -1; lowrun = 0; ndone = 0; done_t = -1;
    busy_drop = -1; nfs = 0; a5_d0 = '0; a5_d1 = '0;
    runs.delete(); fs_t.delete(); fs_idx.delete();
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    if (flag) begin
      nflag++;
      if (first_flag < 0) first_flag = t;
      if (lowrun > 0) runs.push_back(lowrun);
      lowrun = 0;
    end else if (nflag > 0) begin
      lowrun++;
    end
    if (done) begin ndone++; done_t = t; end
    if (frame_start) begin nfs++; fs_t.push_back(t); fs_idx.push_back(frame_idx); end
    if (t >= 10 && t <= 13) begin a5_d0[t - 10] = data0; a5_d1[t - 10] = data1; end
    if (t > 0 && !busy && busy_drop < 0) busy_drop = t;
  endtask

  task automatic launch(input logic [7:0] base);
    src_idx = 0; src_base = base; exp_q.delete(); mph = 0; src_en = 1'b1; sb_en = 1'b1;
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_burst(input int poke_t);
    while (busy_drop < 0 && t < 400) begin
      start = (t == poke_t);
      step();
    end
    start = 1'b0;
    chk("burst_finished", 32'(busy_drop >= 0), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_flag"}, 32'(flag), 32'd0);
    chk({tag, "_data"}, 32'({data1, data0}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset_fidx", 32'(frame_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal burst; a start pulse during the gap must be ignored.
    launch(8'h00);
    run_burst(26);
    chk("nom_first_flag", 32'(first_flag), 32'd2);
    chk("nom_flag_cycles", 32'(nflag), 32'd48);
    chk("nom_low_runs", 32'(runs.size()), 32'd1);
    chk("nom_gap_len", 32'(runs.size() > 0 ? runs[0] : -1), 32'd3);
    chk("nom_fstarts", 32'(nfs), 32'd2);
    chk("nom_fs0_t", 32'(fs_t.size() > 0 ? fs_t[0] : -1), 32'd0);
    chk("nom_fs1_t", 32'(fs_t.size() > 1 ? fs_t[1] : -1), 32'd28);
    chk("nom_fs0_idx", 32'(fs_idx.size() > 0 ? fs_idx[0] : 16'hFFFF), 32'd0);
    chk("nom_fs1_idx", 32'(fs_idx.size() > 1 ? fs_idx[1] : 16'hFFFF), 32'd1);
    chk("nom_done_cnt", 32'(ndone), 32'd1);
    chk("nom_done_t", 32'(done_t), 32'd53);
    chk("nom_busy_drop", 32'(busy_drop), 32'd54);
    chk("nom_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    chk("idle_fidx_hold", 32'(frame_idx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Payload starting with A5 to pin down nibble phase ordering.
    launch(8'hA5);
    run_burst(-1);
    chk("a5_data0", 32'(a5_d0), 32'h5);
    chk("a5_data1", 32'(a5_d1), 32'hA);
    chk("a5_done_t", 32'(done_t), 32'd53);
    chk("a5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Source underflow before payload byte 2.
    hold_arm = 1'b1;
    launch(8'h10);
    run_burst(-1);
    chk("uf_low_runs", 32'(runs.size()), 32'd2);
    chk("uf_stall_len", 32'(runs.size() > 0 ? runs[0] : -1), 32'd5);
    chk("uf_gap_len", 32'(runs.size() > 1 ? runs[1] : -1), 32'd3);
    chk("uf_flag_cycles", 32'(nflag), 32'd48);
    chk("uf_bytes", 32'(src_idx), 32'd8);
    chk("uf_done_t", 32'(done_t), 32'd58);
    chk("uf_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort during payload nibble phase 1.
    launch(8'h00);
    while (t < 10) step();
    chk("ab_pre_flag", 32'(flag), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_flag", 32'(flag), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ready", 32'(byte_ready), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    src_en = 1'b0;
    repeat (5) step();
    chk("ab_no_done", 32'(ndone), 32'd0);
    chk("ab_idle", 32'(busy), 32'd0);
    launch(8'h40);
    run_burst(-1);
    chk("ab_re_fidx", 32'(fs_idx.size() > 0 ? fs_idx[0] : 16'hFFFF), 32'd0);
    chk("ab_re_first_flag", 32'(first_flag), 32'd2);
    chk("ab_re_done", 32'(ndone), 32'd1);
    chk("ab_re_sb_empty", 32'(exp_q.size()), 32'd0);

    // start and abort together while idle.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_fstart", 32'(frame_start), 32'd0);
    step();
    chk("sa_busy2", 32'(busy), 32'd0);
    chk("sa_flag", 32'(flag), 32'd0);

    // Reset in the middle of the header.
    launch(8'h00);
    while (t < 3) step();
    chk("rh_pre_flag", 32'(flag), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_quiet("rh");
    chk("rh_fidx", 32'(frame_idx), 32'd0);
    repeat (3) step();
    chk("rh_quiet_flag", 32'(flag), 32'd0);
    chk("rh_quiet_busy", 32'(busy), 32'd0);
    launch(8'h20);
    run_burst(-1);
    chk("rh_re_first_flag", 32'(first_flag), 32'd2);
    chk("rh_re_flags", 32'(nflag), 32'd48);
    chk("rh_re_done", 32'(ndone), 32'd1);
    chk("rh_re_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
